// File: rtl/alu_req_responder.sv
// Two-stage valid/ready responder around the MIPS ALU function set.
// Stage 1 registers operands, stage 2 registers the result and drives rsp_* directly.
module alu_req_responder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_f,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      done_count
);

  logic             s1_valid;
  logic [2:0]       s1_f;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] alu_y;
  logic             alu_illegal;
  logic             slt;

  // Ready chain is independent of req_valid so upstream can rely on it combinationally.
  assign adv2      = !rsp_valid || rsp_ready;
  assign adv1      = !s1_valid || adv2;
  assign req_ready = adv1;

  // Signed compare is exact; it does not derive the result from a-b, so overflow is moot.
  assign slt = $signed(s1_a) < $signed(s1_b);

  always_comb begin
    alu_y       = '0;
    alu_illegal = 1'b0;
    case (s1_f)
      3'b000:  alu_y = s1_a & s1_b;
      3'b001:  alu_y = s1_a | s1_b;
      3'b010:  alu_y = s1_a + s1_b;
      3'b011:  alu_illegal = 1'b1;
      3'b100:  alu_y = s1_a & ~s1_b;
      3'b101:  alu_y = s1_a | ~s1_b;
      3'b110:  alu_y = s1_a - s1_b;
      default: alu_y = {{(WIDTH-1){1'b0}}, slt};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (adv1) begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_f   <= req_f;
        s1_a   <= req_a;
        s1_b   <= req_b;
        s1_tag <= req_tag;
      end
    end
  end

  // Payload only updates on a real item, so it holds its last value after draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_y       <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= '0;
    end else if (adv2) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_y       <= alu_y;
        rsp_zero    <= (alu_y == '0);
        rsp_illegal <= alu_illegal;
        rsp_tag     <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      done_count <= done_count + 32'd1;
    end
  end

endmodule
